ibex_cx_stacker: RTL and testbench
==================================

// Module: ibex_cx_stacker
// PURPOSE
//  Hardware context save/restore engine for fast interrupt entry and exit.
//  It sits beside the register file. On save it takes the 15x32b cx_store
//  snapshot and streams it word by word to the stack through a data-memory
//  port. On restore it reads 15 words back and presents them on cx_restore
//  for the register file to load.
// PARAMETERS
//  DataWidth  32  width of one register word (only 32 is supported)
//  NumRegs    15  number of words per context
//  CxIfWidth  DataWidth*NumRegs (localparam) context vector width
// PORTS
//  clk_i               in   1          clock
//  rst_i               in   1          synchronous, active-high reset
//  save_req_i          in   1          start a context save (sampled in IDLE)
//  restore_req_i       in   1          start a context restore (sampled in IDLE)
//  sp_i                in   32         stack pointer at the request cycle
//  cx_store_i          in   CxIfWidth  register snapshot; word k = [32k+:32]
//  cx_restore_o        out  CxIfWidth  assembled restore context
//  cx_restore_valid_o  out  1          1-cycle pulse: register file loads cx_restore_o
//  busy_o              out  1          engine active
//  done_o              out  1          1-cycle completion pulse
//  err_o               out  1          1-cycle pulse with done_o on a bus error
//  data_req_o          out  1          memory request
//  data_gnt_i          in   1          memory grant
//  data_we_o           out  1          1 = write (save), 0 = read (restore)
//  data_addr_o         out  32         word address (byte-addressed, [1:0]=0)
//  data_be_o           out  4          always 4'hF while data_req_o is high
//  data_wdata_o        out  32         write data
//  data_rvalid_i       in   1          response valid
//  data_rdata_i        in   32         read data
//  data_err_i          in   1          response error (qualified by rvalid)
// BEHAVIOUR
//  - Reset (rst_i=1 at a posedge): FSM goes to IDLE, all outputs are 0,
//    cx_restore_o is 0, and the word counter is 0. Reset mid-operation aborts
//    with no done_o. A pending rvalid that arrives later is ignored in IDLE.
//  - FSM states: IDLE, REQ, WAIT, DONE.
//  - IDLE: when save_req_i=1, latch cx_store_i, set base = sp_i - 4*NumRegs
//    (mod 2^32), set op = save, and go to REQ. Otherwise, when
//    restore_req_i=1, set base = sp_i, set op = restore, and go to REQ.
//  - Save has priority when both requests are high. Requests are ignored
//    outside IDLE.
//  - REQ: drive data_req_o=1 and data_addr_o = base + 4*k (mod 2^32), with
//    we = op. Address, wdata and we stay stable until data_gnt_i. On grant,
//    go to WAIT.
//  - WAIT: data_req_o=0; only one transaction is outstanding. On
//    data_rvalid_i:
//      - If data_err_i=1, go to DONE with the error flag set. Remaining words
//        are skipped.
//      - Otherwise, on restore, write data_rdata_i into staging word k.
//      - If k==NumRegs-1, go to DONE; else increment k and return to REQ.
//  - DONE (one cycle): done_o=1 and err_o=flag. On a restore with no error,
//    cx_restore_valid_o=1 and cx_restore_o takes the staging value. Next
//    state is IDLE, with k and flag cleared.
//  - cx_restore_o changes only on an error-free restore completion. A failed
//    restore leaves the previous value.
//  - busy_o=1 in REQ, WAIT and DONE.
//  - Latency with zero-wait memory (gnt in the request cycle, rvalid the next
//    cycle): request accepted at edge 0; word k granted in cycle 1+2k;
//    done_o in cycle 2*NumRegs+1 (=31).
//  - A new request may be accepted in the cycle after DONE.
//  - data_wdata_o=0 when not saving. data_rdata_i is ignored on save.
// TESTING
//  - Save, zero-wait memory, sp_i=0x1000, word k=0xA000_0000+k:
//    writes to 0x0FC4..0x0FFC ascending with matching data; done_o at
//    cycle 31; err_o=0.
//  - Restore, sp_i=0x0FC4, memory returns 0xB000_0000+k, with 3-cycle gnt
//    stalls: cx_restore_o word k = 0xB000_0000+k; cx_restore_valid_o and
//    done_o pulse together; address and we stay stable during stalls.
//  - save_req_i and restore_req_i high together in IDLE -> save executes;
//    restore_req_i during busy is ignored, with no extra transactions.
//  - Restore with data_err_i on word 5 -> exactly 6 requests; done_o=err_o=1;
//    no cx_restore_valid_o; cx_restore_o unchanged.
//  - Save with sp_i=0x0000_0020 -> base wraps to 0xFFFF_FFE4; addresses
//    0xFFFF_FFE4..0x0000_001C in order.
//  - rst_i asserted in WAIT of word 7, with rvalid arriving after reset ->
//    all outputs 0 next cycle; no done_o; a subsequent save runs cleanly.

Source files
------------

// File: rtl/ibex_cx_stacker.sv
// ibex_cx_stacker
// Context save/restore engine for fast interrupt entry and exit.
// A save copies the 15-word cx_store_i snapshot to the stack, one word per
// memory transaction, at ascending addresses starting at sp_i - 4*NumRegs.
// A restore reads 15 words starting at sp_i and hands them to the register
// file as one vector on cx_restore_o, qualified by a single-cycle
// cx_restore_valid_o pulse.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   save_req_i              start a save (IDLE only, wins over restore)
//   restore_req_i           start a restore (IDLE only)
//   sp_i                    stack pointer in the request cycle
//   cx_store_i              register snapshot, word k = [32k +: 32]
//   cx_restore_o            restored context
//   cx_restore_valid_o      register file load strobe
//   busy_o, done_o, err_o   status; err_o pulses with done_o on a bus error
//   data_*                  data-memory port, one outstanding transaction
//
// state  | meaning
// IDLE   | waiting for save_req_i / restore_req_i
// REQ    | request for word k on the bus, held until data_gnt_i
// WAIT   | granted, waiting for data_rvalid_i
// DONE   | one-cycle completion, done_o / err_o / cx_restore_valid_o
module ibex_cx_stacker #(
    parameter int  DataWidth = 32,
    parameter int  NumRegs   = 15,
    localparam int CxIfWidth = DataWidth * NumRegs
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 save_req_i,
    input  logic                 restore_req_i,
    input  logic [31:0]          sp_i,
    input  logic [CxIfWidth-1:0] cx_store_i,
    output logic [CxIfWidth-1:0] cx_restore_o,
    output logic                 cx_restore_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    output logic                 data_we_o,
    output logic [31:0]          data_addr_o,
    output logic [3:0]           data_be_o,
    output logic [31:0]          data_wdata_o,
    input  logic                 data_rvalid_i,
    input  logic [31:0]          data_rdata_i,
    input  logic                 data_err_i
);

    localparam int CntW = $clog2(NumRegs);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic                                 r_op_save;
    logic                                 r_err;
    logic [31:0]                          r_base;
    logic [CntW-1:0]                      r_k;
    logic [NumRegs-1:0][DataWidth-1:0]    r_store;
    logic [NumRegs-1:0][DataWidth-1:0]    r_stage;
    logic [NumRegs-1:0][DataWidth-1:0]    r_restore;
    logic                                 w_last;
    logic                                 w_restore_valid;
    logic [31:0]                          w_addr;

    assign w_last = (r_k == CntW'(NumRegs - 1));
    assign w_addr = r_base + (32'(r_k) << 2);
    assign w_restore_valid = (r_state == S_DONE) && !r_op_save && !r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (save_req_i || restore_req_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (data_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_rvalid_i) begin
                    // an error response ends the operation early
                    if (data_err_i || w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op_save <= 1'b0;
            r_err     <= 1'b0;
            r_base    <= '0;
            r_k       <= '0;
            r_store   <= '0;
            r_stage   <= '0;
            r_restore <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (save_req_i) begin
                        r_op_save <= 1'b1;
                        r_base    <= sp_i - 32'(4 * NumRegs);
                        r_store   <= cx_store_i;
                    end else if (restore_req_i) begin
                        r_op_save <= 1'b0;
                        r_base    <= sp_i;
                    end
                end
                S_WAIT: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            r_err <= 1'b1;
                        end else begin
                            if (!r_op_save) begin
                                r_stage[r_k] <= data_rdata_i;
                            end
                            if (!w_last) begin
                                r_k <= r_k + CntW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    // staging only becomes visible context after a clean restore
                    if (w_restore_valid) begin
                        r_restore <= r_stage;
                    end
                    r_k   <= '0;
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_req_o         = 1'b0;
        data_we_o          = 1'b0;
        data_addr_o        = '0;
        data_be_o          = '0;
        data_wdata_o       = '0;
        busy_o             = (r_state != S_IDLE);
        done_o             = 1'b0;
        err_o              = 1'b0;
        cx_restore_valid_o = 1'b0;
        // during the load strobe the freshly staged words are presented directly
        cx_restore_o       = w_restore_valid ? r_stage : r_restore;
        case (r_state)
            S_REQ: begin
                data_req_o  = 1'b1;
                data_we_o   = r_op_save;
                data_addr_o = w_addr;
                data_be_o   = 4'hF;
                if (r_op_save) begin
                    data_wdata_o = r_store[r_k];
                end
            end
            S_DONE: begin
                done_o             = 1'b1;
                err_o              = r_err;
                cx_restore_valid_o = w_restore_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ibex_cx_stacker.sv
module tb_ibex_cx_stacker;

    localparam int NR = 15;
    localparam int CW = 32 * NR;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          save_req_i;
    logic          restore_req_i;
    logic [31:0]   sp_i;
    logic [CW-1:0] cx_store_i;
    logic [CW-1:0] cx_restore_o;
    logic          cx_restore_valid_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          data_req_o;
    logic          data_gnt_i;
    logic          data_we_o;
    logic [31:0]   data_addr_o;
    logic [3:0]    data_be_o;
    logic [31:0]   data_wdata_o;
    logic          data_rvalid_i;
    logic [31:0]   data_rdata_i;
    logic          data_err_i;

    ibex_cx_stacker #(.DataWidth(32), .NumRegs(NR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .save_req_i(save_req_i), .restore_req_i(restore_req_i),
        .sp_i(sp_i), .cx_store_i(cx_store_i),
        .cx_restore_o(cx_restore_o), .cx_restore_valid_o(cx_restore_valid_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
        .data_addr_o(data_addr_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic        save;
        logic        restore;
        logic [31:0] sp;
        int          stall;
        int          dly;
        int          err_at;
        logic        poke;
        int          exp_n;
        logic        exp_err;
        logic        exp_val;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    // memory responder configuration and transaction log
    int          cfg_stall = 0;
    int          cfg_dly   = 1;
    int          cfg_err_at = -1;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_wd[$];
    int          stab_bad = 0;
    int          be_bad   = 0;

    // completion monitor
    int            done_cnt = 0;
    int            done_rel = 0;
    logic          done_err = 1'b0;
    int            val_cnt  = 0;
    int            val_bad  = 0;
    int            err_bad  = 0;
    logic [CW-1:0] cap_restore = '0;

    logic [CW-1:0] exp_restore = '0;
    logic [31:0]   sw_a[NR];
    logic [31:0]   rw_a[NR];
    vec_t          tbl[8];
    vec_t          rv;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int          rsp_wait;
        logic        rsp_err;
        logic [31:0] rsp_data;
        int          stall_left;
        logic        in_stall;
        logic [31:0] st_addr;
        logic [31:0] st_wd;
        logic        st_we;
        rsp_wait = 0; rsp_err = 1'b0; rsp_data = '0; stall_left = 0; in_stall = 1'b0;
        st_addr = '0; st_wd = '0; st_we = 1'b0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            data_err_i    = 1'($urandom);
            data_rdata_i  = $urandom;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    data_rvalid_i = 1'b1;
                    data_err_i    = rsp_err;
                    data_rdata_i  = rsp_data;
                end
            end
            if (!data_req_o) begin
                stall_left = cfg_stall;
                in_stall   = 1'b0;
            end else begin
                if (data_be_o !== 4'hF) be_bad++;
                if (in_stall && (data_addr_o !== st_addr || data_we_o !== st_we || data_wdata_o !== st_wd))
                    stab_bad++;
                st_addr = data_addr_o; st_we = data_we_o; st_wd = data_wdata_o;
                in_stall = 1'b1;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    data_gnt_i = 1'b1;
                    in_stall   = 1'b0;
                    log_addr.push_back(data_addr_o);
                    log_we.push_back(data_we_o);
                    log_wd.push_back(data_wdata_o);
                    rsp_err = ((log_addr.size() - 1) == cfg_err_at);
                    if (data_we_o) begin
                        mem[data_addr_o] = data_wdata_o;
                        rsp_data = $urandom;
                    end else begin
                        rsp_data = mem.exists(data_addr_o) ? mem[data_addr_o] : 32'h0;
                    end
                    rsp_wait = cfg_dly;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (done_o) begin
            done_cnt++;
            done_rel = cyc - t0 + 1;
            done_err = err_o;
        end
        if (err_o && !done_o) err_bad++;
        if (cx_restore_valid_o) begin
            val_cnt++;
            cap_restore = cx_restore_o;
            if (!done_o) val_bad++;
        end
    end

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_err = (v.err_at >= 0) && (v.err_at < NR);
        r.exp_n   = r.exp_err ? v.err_at + 1 : NR;
        r.exp_val = !v.save && !r.exp_err;
        return r;
    endfunction

    task automatic start_op(input vec_t v);
        logic [CW-1:0] st;
        for (int k = 0; k < NR; k++) st[32*k +: 32] = sw_a[k];
        cfg_stall = v.stall; cfg_dly = v.dly; cfg_err_at = v.err_at;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        @(negedge clk_i);
        save_req_i = v.save; restore_req_i = v.restore; sp_i = v.sp; cx_store_i = st;
        @(posedge clk_i);
        #1;
        t0 = cyc;
        save_req_i = 1'b0; restore_req_i = 1'b0;
        sp_i = $urandom; cx_store_i = ~st;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0]   base;
        logic [31:0]   ea;
        logic [CW-1:0] rexp;
        int            dc0, vc0, n, lim;
        base = v.save ? v.sp - 32'(4 * NR) : v.sp;
        for (int k = 0; k < NR; k++) rexp[32*k +: 32] = rw_a[k];
        if (!v.save) for (int k = 0; k < NR; k++) mem[base + 32'(4 * k)] = rw_a[k];
        dc0 = done_cnt; vc0 = val_cnt;
        stab_bad = 0; be_bad = 0; val_bad = 0; err_bad = 0;
        start_op(v);
        chk32({tag, " busy_start"}, 32'(busy_o), 32'd1);
        if (v.poke) begin
            repeat (4) @(posedge clk_i);
            #1 save_req_i = 1'b1; restore_req_i = 1'b1;
            repeat (3) @(posedge clk_i);
            #1 save_req_i = 1'b0; restore_req_i = 1'b0;
        end
        n = 0;
        while (done_cnt == dc0 && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        chk32({tag, " done_count"}, 32'(done_cnt - dc0), 32'd1);
        #1;
        chk32({tag, " idle_after"}, {30'd0, busy_o, done_o}, 32'd0);
        chk32({tag, " n_txn"}, 32'(log_addr.size()), 32'(v.exp_n));
        lim = (log_addr.size() < v.exp_n) ? log_addr.size() : v.exp_n;
        for (int j = 0; j < lim; j++) begin
            ea = base + 32'(4 * j);
            chk32($sformatf("%s addr%0d", tag, j), log_addr[j], ea);
            chk32($sformatf("%s we%0d", tag, j), 32'(log_we[j]), 32'(v.save));
            chk32($sformatf("%s wdata%0d", tag, j), log_wd[j], v.save ? sw_a[j] : 32'h0);
        end
        chk32({tag, " err"}, 32'(done_err), 32'(v.exp_err));
        chk32({tag, " valid_cnt"}, 32'(val_cnt - vc0), 32'(v.exp_val));
        chk32({tag, " latency"}, 32'(done_rel), 32'(v.exp_n * (v.stall + v.dly + 1) + 1));
        chk32({tag, " stable_bad"}, 32'(stab_bad), 32'd0);
        chk32({tag, " be_bad"}, 32'(be_bad), 32'd0);
        chk32({tag, " pulse_bad"}, 32'(val_bad + err_bad), 32'd0);
        if (v.exp_val) begin
            chkw({tag, " restore_at_valid"}, cap_restore, rexp);
            exp_restore = rexp;
        end
        chkw({tag, " restore_hold"}, cx_restore_o, exp_restore);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0, n;
        rst_i = 1'b1; save_req_i = 1'b0; restore_req_i = 1'b0; sp_i = '0; cx_store_i = '0;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1000, 0, 1, -1, 1'b0, 15, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0FC4, 3, 1, -1, 1'b0, 15, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_2000, 0, 2, -1, 1'b1, 15, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_4000, 1, 1,  5, 1'b0,  6, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0020, 0, 1, -1, 1'b0, 15, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h0000_8000, 0, 3, 14, 1'b0, 15, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0100, 2, 1,  0, 1'b0,  1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFF0, 0, 1, -1, 1'b1, 15, 1'b0, 1'b1};

        repeat (3) @(posedge clk_i);
        #1;
        chk32("reset_ctrl", {22'd0, busy_o, done_o, err_o, cx_restore_valid_o, data_req_o, data_we_o, data_be_o},
              32'd0);
        chk32("reset_addr", data_addr_o, 32'd0);
        chk32("reset_wdata", data_wdata_o, 32'd0);
        chkw("reset_restore", cx_restore_o, '0);
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NR; k++) begin
                sw_a[k] = 32'hA000_0000 + 32'(k) + 32'(i << 8);
                rw_a[k] = (i == 1) ? 32'hB000_0000 + 32'(k) : 32'hB000_0000 + 32'(i << 16) + 32'(k);
            end
            if (i == 0) for (int k = 0; k < NR; k++) sw_a[k] = 32'hA000_0000 + 32'(k);
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // reset while word 7 of a save is outstanding; its response lands in IDLE
        rv = '{1'b1, 1'b0, 32'h0000_3000, 0, 4, -1, 1'b0, 15, 1'b0, 1'b0};
        for (int k = 0; k < NR; k++) sw_a[k] = 32'hC000_0000 + 32'(k);
        dc0 = done_cnt;
        start_op(rv);
        n = 0;
        while (log_addr.size() < 8 && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        chk32("abort_reached_w7", 32'(log_addr.size()), 32'd8);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk32("abort_ctrl", {22'd0, busy_o, done_o, err_o, cx_restore_valid_o, data_req_o, data_we_o, data_be_o},
              32'd0);
        chk32("abort_addr", data_addr_o, 32'd0);
        chkw("abort_restore", cx_restore_o, '0);
        exp_restore = '0;
        repeat (6) @(posedge clk_i);
        chk32("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        chk32("abort_no_txn", 32'(log_addr.size()), 32'd8);
        rv = '{1'b1, 1'b0, 32'h0000_5000, 0, 1, -1, 1'b0, 15, 1'b0, 1'b0};
        run_vec(rv, "after_abort");

        for (int r = 0; r < 24; r++) begin
            rv.save    = 1'($urandom);
            rv.restore = 1'($urandom);
            if (!rv.save && !rv.restore) rv.restore = 1'b1;
            rv.sp      = $urandom & 32'hFFFF_FFFC;
            rv.stall   = int'($urandom_range(0, 3));
            rv.dly     = int'($urandom_range(1, 3));
            rv.err_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
            rv.poke    = 1'b0;
            rv = model(rv);
            for (int k = 0; k < NR; k++) begin
                sw_a[k] = $urandom;
                rw_a[k] = $urandom;
            end
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
